// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if: ID-side operands/control in, EX-side pipeline register out
interface id_ex_operand_stage_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              id_valid;
   logic [ADDR_W-1:0] p0_addr;
   logic [ADDR_W-1:0] p1_addr;
   logic              re0;
   logic              re1;
   logic [DATA_W-1:0] p0;
   logic [DATA_W-1:0] p1;
   logic [ADDR_W-1:0] id_dst_addr;
   logic              id_we;
   logic              id_mem_rd;
   logic              id_hlt;
   logic              flush;
   logic              exm_we;
   logic [ADDR_W-1:0] exm_dst_addr;
   logic [DATA_W-1:0] exm_result;
   logic [DATA_W-1:0] ex_a;
   logic [DATA_W-1:0] ex_b;
   logic [ADDR_W-1:0] ex_dst_addr;
   logic              ex_we;
   logic              ex_mem_rd;
   logic              ex_valid;
   logic              stall_req;
   logic              halted;

   modport master (
      output id_valid, p0_addr, p1_addr, re0, re1, p0, p1, id_dst_addr, id_we,
             id_mem_rd, id_hlt, flush, exm_we, exm_dst_addr, exm_result,
      input  ex_a, ex_b, ex_dst_addr, ex_we, ex_mem_rd, ex_valid, stall_req, halted
   );

   modport slave (
      input  id_valid, p0_addr, p1_addr, re0, re1, p0, p1, id_dst_addr, id_we,
             id_mem_rd, id_hlt, flush, exm_we, exm_dst_addr, exm_result,
      output ex_a, ex_b, ex_dst_addr, ex_we, ex_mem_rd, ex_valid, stall_req, halted
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with EX/MEM forwarding, load-use bubbles and halt drain
module id_ex_operand_stage #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 4,
   parameter int DRAIN_CYC = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   id_ex_operand_stage_if.slave stage_if
);
   localparam int CW = $clog2(DRAIN_CYC + 1);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic              halted_q;
   logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
   logic [ADDR_W-1:0] ex_dst_q, ex_dst_d;
   logic              ex_we_q, ex_we_d, ex_mem_rd_q, ex_mem_rd_d, ex_valid_q, ex_valid_d;
   logic              hazard, stall, capture, hlt_cap;

   // Hazard/priority decode and forwarded operand select; R0 always reads zero
   always_comb begin
      hazard      = ex_valid_q && ex_mem_rd_q && ex_we_q && ex_dst_q != '0 && stage_if.id_valid &&
                    ((stage_if.re0 && stage_if.p0_addr == ex_dst_q) ||
                     (stage_if.re1 && stage_if.p1_addr == ex_dst_q));
      stall       = state_q == RUN && !stage_if.flush && hazard;
      capture     = state_q == RUN && !stage_if.flush && !stall;
      hlt_cap     = capture && stage_if.id_valid && stage_if.id_hlt;
      ex_a_d      = stage_if.p0_addr == '0 ? '0 :
                    (stage_if.exm_we && stage_if.exm_dst_addr == stage_if.p0_addr) ? stage_if.exm_result : stage_if.p0;
      ex_b_d      = stage_if.p1_addr == '0 ? '0 :
                    (stage_if.exm_we && stage_if.exm_dst_addr == stage_if.p1_addr) ? stage_if.exm_result : stage_if.p1;
      ex_dst_d    = stage_if.id_dst_addr;
      ex_valid_d  = capture && stage_if.id_valid && !stage_if.id_hlt;
      ex_we_d     = ex_valid_d && stage_if.id_we;
      ex_mem_rd_d = ex_valid_d && stage_if.id_mem_rd;
   end

   // EX pipeline register; bubbles only clear the control bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_a_q      <= '0;
         ex_b_q      <= '0;
         ex_dst_q    <= '0;
         ex_we_q     <= 1'b0;
         ex_mem_rd_q <= 1'b0;
         ex_valid_q  <= 1'b0;
      end else begin
         ex_a_q      <= ex_a_d;
         ex_b_q      <= ex_b_d;
         ex_dst_q    <= ex_dst_d;
         ex_we_q     <= ex_we_d;
         ex_mem_rd_q <= ex_mem_rd_d;
         ex_valid_q  <= ex_valid_d;
      end
   end

   // Halt sequencer: drain EX/MEM/WB after HLT capture, then hold halted until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         cnt_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         halted_q <= state_q == HALTED;
         case (state_q)
            RUN: if (hlt_cap) begin
               state_q <= DRAIN;
               cnt_q   <= '0;
            end
            DRAIN: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(DRAIN_CYC - 1)) state_q <= HALTED;
            end
            default: state_q <= HALTED;
         endcase
      end
   end

   assign stage_if.ex_a        = ex_a_q;
   assign stage_if.ex_b        = ex_b_q;
   assign stage_if.ex_dst_addr = ex_dst_q;
   assign stage_if.ex_we       = ex_we_q;
   assign stage_if.ex_mem_rd   = ex_mem_rd_q;
   assign stage_if.ex_valid    = ex_valid_q;
   assign stage_if.stall_req   = stall;
   assign stage_if.halted      = halted_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed checks of capture, forwarding, load-use, flush and halt drain
module tb_id_ex_operand_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total = 0;

   id_ex_operand_stage_if #(.DATA_W(16), .ADDR_W(4)) ifc ();

   id_ex_operand_stage #(.DATA_W(16), .ADDR_W(4), .DRAIN_CYC(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .stage_if (ifc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ifc.id_valid = 1'b1; ifc.p0_addr = 4'd1; ifc.p1_addr = 4'd2; ifc.re0 = 1'b1; ifc.re1 = 1'b1;
      ifc.p0 = 16'hFFFF; ifc.p1 = 16'hFFFF; ifc.id_dst_addr = 4'd7; ifc.id_we = 1'b1;
      ifc.id_mem_rd = 1'b1; ifc.id_hlt = 1'b0; ifc.flush = 1'b0;
      ifc.exm_we = 1'b0; ifc.exm_dst_addr = 4'd0; ifc.exm_result = 16'h0;
      step(); step();
      chk("rst_ex_a", 32'(ifc.ex_a), 32'h0);
      chk("rst_ex_b", 32'(ifc.ex_b), 32'h0);
      chk("rst_dst", 32'(ifc.ex_dst_addr), 32'h0);
      chk("rst_we", 32'(ifc.ex_we), 32'h0);
      chk("rst_mem_rd", 32'(ifc.ex_mem_rd), 32'h0);
      chk("rst_valid", 32'(ifc.ex_valid), 32'h0);
      chk("rst_halted", 32'(ifc.halted), 32'h0);
      // plain capture on the first edge after release
      rst_n = 1'b1;
      ifc.p0_addr = 4'd3; ifc.p0 = 16'h1234; ifc.p1_addr = 4'd4; ifc.p1 = 16'h00AB;
      ifc.id_dst_addr = 4'd5; ifc.id_mem_rd = 1'b0;
      step();
      chk("cap_a", 32'(ifc.ex_a), 32'h1234);
      chk("cap_b", 32'(ifc.ex_b), 32'h00AB);
      chk("cap_dst", 32'(ifc.ex_dst_addr), 32'h5);
      chk("cap_we", 32'(ifc.ex_we), 32'h1);
      chk("cap_valid", 32'(ifc.ex_valid), 32'h1);
      chk("cap_mem_rd", 32'(ifc.ex_mem_rd), 32'h0);
      // EX/MEM forwarding into A
      ifc.exm_we = 1'b1; ifc.exm_dst_addr = 4'd3; ifc.exm_result = 16'hBEEF; ifc.p0 = 16'h1111;
      step();
      chk("fwd_a", 32'(ifc.ex_a), 32'hBEEF);
      chk("fwd_a_b", 32'(ifc.ex_b), 32'h00AB);
      // R0 never forwarded
      ifc.p0_addr = 4'd0; ifc.exm_dst_addr = 4'd0;
      step();
      chk("r0_a", 32'(ifc.ex_a), 32'h0);
      // forwarding into B only
      ifc.p0_addr = 4'd3; ifc.exm_dst_addr = 4'd4; ifc.exm_result = 16'h5555;
      step();
      chk("fwd_b_a", 32'(ifc.ex_a), 32'h1111);
      chk("fwd_b", 32'(ifc.ex_b), 32'h5555);
      // address match without exm_we does not forward
      ifc.exm_we = 1'b0; ifc.exm_dst_addr = 4'd3;
      step();
      chk("nowe_a", 32'(ifc.ex_a), 32'h1111);
      // load to R6 enters EX
      ifc.id_mem_rd = 1'b1; ifc.id_dst_addr = 4'd6; ifc.re0 = 1'b0; ifc.re1 = 1'b0;
      step();
      chk("ld_mem_rd", 32'(ifc.ex_mem_rd), 32'h1);
      chk("ld_dst", 32'(ifc.ex_dst_addr), 32'h6);
      // dependent instruction reads R6 on p1
      ifc.id_mem_rd = 1'b0; ifc.id_dst_addr = 4'd7; ifc.p0_addr = 4'd2; ifc.re0 = 1'b1;
      ifc.p1_addr = 4'd6; ifc.re1 = 1'b1; ifc.p1 = 16'h9999;
      #1;
      chk("lu_stall", 32'(ifc.stall_req), 32'h1);
      step();
      chk("lu_bub_valid", 32'(ifc.ex_valid), 32'h0);
      chk("lu_bub_we", 32'(ifc.ex_we), 32'h0);
      chk("lu_bub_mem_rd", 32'(ifc.ex_mem_rd), 32'h0);
      chk("lu_unstall", 32'(ifc.stall_req), 32'h0);
      // re-presented instruction forwards the load result
      ifc.exm_we = 1'b1; ifc.exm_dst_addr = 4'd6; ifc.exm_result = 16'h0042;
      step();
      chk("lu_fwd_b", 32'(ifc.ex_b), 32'h0042);
      chk("lu_valid", 32'(ifc.ex_valid), 32'h1);
      chk("lu_dst", 32'(ifc.ex_dst_addr), 32'h7);
      // flush beats stall
      ifc.exm_we = 1'b0; ifc.id_mem_rd = 1'b1; ifc.id_dst_addr = 4'd6; ifc.re0 = 1'b0; ifc.re1 = 1'b0;
      step();
      ifc.id_mem_rd = 1'b0; ifc.id_dst_addr = 4'd8; ifc.re1 = 1'b1;
      #1;
      chk("fl_pre_stall", 32'(ifc.stall_req), 32'h1);
      ifc.flush = 1'b1;
      #1;
      chk("fl_stall", 32'(ifc.stall_req), 32'h0);
      step();
      chk("fl_valid", 32'(ifc.ex_valid), 32'h0);
      chk("fl_we", 32'(ifc.ex_we), 32'h0);
      // halt capture then drain
      ifc.flush = 1'b0; ifc.re0 = 1'b0; ifc.re1 = 1'b0; ifc.id_hlt = 1'b1; ifc.id_we = 1'b1;
      step();
      chk("hlt_valid", 32'(ifc.ex_valid), 32'h0);
      chk("hlt_we", 32'(ifc.ex_we), 32'h0);
      ifc.id_hlt = 1'b0; ifc.id_dst_addr = 4'd9;
      for (int i = 1; i <= 3; i++) begin
         chk($sformatf("drain_halted_%0d", i), 32'(ifc.halted), 32'h0);
         step();
         chk($sformatf("drain_we_%0d", i), 32'(ifc.ex_we), 32'h0);
         chk($sformatf("drain_valid_%0d", i), 32'(ifc.ex_valid), 32'h0);
      end
      chk("drain_pre4", 32'(ifc.halted), 32'h0);
      step();
      chk("halted_edge4", 32'(ifc.halted), 32'h1);
      step(); step();
      chk("halted_hold", 32'(ifc.halted), 32'h1);
      chk("halted_we", 32'(ifc.ex_we), 32'h0);
      // asynchronous reset clears halted, then HLT squashed by flush
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_halted", 32'(ifc.halted), 32'h0);
      step();
      rst_n = 1'b1; ifc.id_hlt = 1'b1; ifc.flush = 1'b1;
      step();
      ifc.id_hlt = 1'b0; ifc.flush = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("fl_hlt_halted", 32'(ifc.halted), 32'h0);
      chk("fl_hlt_valid", 32'(ifc.ex_valid), 32'h1);
      chk("fl_hlt_dst", 32'(ifc.ex_dst_addr), 32'h9);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
